// File: rtl/pool2_engine.sv
// 2x2/stride-2 signed max-pool over a 3-channel 8x8 map into a 3-channel 4x4 map, optional ReLU.
// Latency: first write 6 cycles after start, one window every 6 cycles, done 289 cycles after start.
// No backpressure: fixed-rate reads/writes; start is ignored while a run is in progress.
module pool2_engine #(
  parameter int DATA_W  = 16,
  parameter bit RELU_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              rd_en,
  output logic [1:0]        rd_ch,
  output logic [5:0]        rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [1:0]        wr_ch,
  output logic [3:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD0   = 3'd1,
    RD1   = 3'd2,
    RD2   = 3'd3,
    RD3   = 3'd4,
    WAIT  = 3'd5,
    WRITE = 3'd6,
    DONE  = 3'd7
  } state_t;

  state_t state, state_nxt;

  logic [1:0] ch, ch_nxt;
  logic [1:0] prow, prow_nxt;
  logic [1:0] pcol, pcol_nxt;
  logic signed [DATA_W-1:0] max_q, max_nxt;
  logic signed [DATA_W-1:0] rd_data_s;

  logic              rd_en_nxt;
  logic [1:0]        rd_ch_nxt;
  logic [5:0]        rd_addr_nxt;
  logic [5:0]        rd_base;
  logic              wr_en_nxt;
  logic [1:0]        wr_ch_nxt;
  logic [3:0]        wr_addr_nxt;
  logic [DATA_W-1:0] wr_data_nxt;
  logic              busy_nxt;
  logic              done_nxt;

  assign rd_data_s = $signed(rd_data);

  // Next state, window counters, running max, and the next value of every registered output.
  // Outputs are derived from the *next* state and counters so they line up with the state they describe.
  always_comb begin
    state_nxt   = state;
    ch_nxt      = ch;
    prow_nxt    = prow;
    pcol_nxt    = pcol;
    max_nxt     = max_q;
    rd_ch_nxt   = rd_ch;
    rd_addr_nxt = rd_addr;
    wr_ch_nxt   = wr_ch;
    wr_addr_nxt = wr_addr;
    wr_data_nxt = wr_data;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = RD0;
          ch_nxt    = 2'd0;
          prow_nxt  = 2'd0;
          pcol_nxt  = 2'd0;
        end
      end
      RD0: state_nxt = RD1;
      RD1: begin
        // First datum of the window is loaded unconditionally.
        state_nxt = RD2;
        max_nxt   = rd_data_s;
      end
      RD2: begin
        state_nxt = RD3;
        if (rd_data_s > max_q) max_nxt = rd_data_s;
      end
      RD3: begin
        state_nxt = WAIT;
        if (rd_data_s > max_q) max_nxt = rd_data_s;
      end
      WAIT: begin
        state_nxt = WRITE;
        if (rd_data_s > max_q) max_nxt = rd_data_s;
      end
      WRITE: begin
        if (ch == 2'd2 && prow == 2'd3 && pcol == 2'd3) begin
          state_nxt = DONE;
        end else begin
          state_nxt = RD0;
          pcol_nxt  = pcol + 2'd1;
          if (pcol == 2'd3) begin
            prow_nxt = prow + 2'd1;
            if (prow == 2'd3) ch_nxt = ch + 2'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Top-left pixel of the window: (2*prow)*8 + 2*pcol.
    rd_base   = {prow_nxt, 1'b0, pcol_nxt, 1'b0};
    rd_en_nxt = (state_nxt == RD0) || (state_nxt == RD1) ||
                (state_nxt == RD2) || (state_nxt == RD3);
    if (rd_en_nxt) begin
      rd_ch_nxt = ch_nxt;
      case (state_nxt)
        RD1:     rd_addr_nxt = rd_base | 6'd1;
        RD2:     rd_addr_nxt = rd_base | 6'd8;
        RD3:     rd_addr_nxt = rd_base | 6'd9;
        default: rd_addr_nxt = rd_base;
      endcase
    end

    wr_en_nxt = (state_nxt == WRITE);
    if (wr_en_nxt) begin
      wr_ch_nxt   = ch_nxt;
      wr_addr_nxt = {prow_nxt, pcol_nxt};
      wr_data_nxt = (RELU_EN && max_nxt[DATA_W-1]) ? '0 : max_nxt;
    end

    busy_nxt = rd_en_nxt || (state_nxt == WAIT) || (state_nxt == WRITE);
    done_nxt = (state_nxt == DONE);
  end

  // State, counters, max register and all outputs, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ch      <= 2'd0;
      prow    <= 2'd0;
      pcol    <= 2'd0;
      max_q   <= '0;
      rd_en   <= 1'b0;
      rd_ch   <= 2'd0;
      rd_addr <= 6'd0;
      wr_en   <= 1'b0;
      wr_ch   <= 2'd0;
      wr_addr <= 4'd0;
      wr_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      ch      <= ch_nxt;
      prow    <= prow_nxt;
      pcol    <= pcol_nxt;
      max_q   <= max_nxt;
      rd_en   <= rd_en_nxt;
      rd_ch   <= rd_ch_nxt;
      rd_addr <= rd_addr_nxt;
      wr_en   <= wr_en_nxt;
      wr_ch   <= wr_ch_nxt;
      wr_addr <= wr_addr_nxt;
      wr_data <= wr_data_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_pool2_engine.sv
// Bench for pool2_engine: two instances (ReLU on / off) fed from one behavioural conv2 memory.
// Checks reset state, timing, strobe counts, ordering, ramp results, table vectors, restarts, mid-run reset.
module tb_pool2_engine;

  localparam int W = 16;

  logic clk = 1'b0;
  logic reset;
  logic start;

  always #5 clk = ~clk;

  // Instance with ReLU enabled
  logic         rd_en1, wr_en1, busy1, done1;
  logic [1:0]   rd_ch1, wr_ch1;
  logic [5:0]   rd_addr1;
  logic [3:0]   wr_addr1;
  logic [W-1:0] rd_data1, wr_data1;

  // Instance with ReLU disabled
  logic         rd_en0, wr_en0, busy0, done0;
  logic [1:0]   rd_ch0, wr_ch0;
  logic [5:0]   rd_addr0;
  logic [3:0]   wr_addr0;
  logic [W-1:0] rd_data0, wr_data0;

  pool2_engine #(.DATA_W(W), .RELU_EN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .start(start),
    .rd_en(rd_en1), .rd_ch(rd_ch1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .wr_en(wr_en1), .wr_ch(wr_ch1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .busy(busy1), .done(done1)
  );

  pool2_engine #(.DATA_W(W), .RELU_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .start(start),
    .rd_en(rd_en0), .rd_ch(rd_ch0), .rd_addr(rd_addr0), .rd_data(rd_data0),
    .wr_en(wr_en0), .wr_ch(wr_ch0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .busy(busy0), .done(done0)
  );

  // conv2 output memory: 1-cycle synchronous read; junk returned when not reading.
  logic [W-1:0] mem [3][64];

  always @(posedge clk) begin
    rd_data1 <= rd_en1 ? mem[rd_ch1][rd_addr1] : W'($urandom);
    rd_data0 <= rd_en0 ? mem[rd_ch0][rd_addr0] : W'($urandom);
  end

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] res1 [48];
  logic [W-1:0] res0 [48];
  logic [W-1:0] prev1 [48];
  logic [W-1:0] prev0 [48];

  typedef struct {
    int           ch;
    int           win;
    logic [W-1:0] v0, v1, v2, v3;
    logic [W-1:0] exp_relu;
    logic [W-1:0] exp_raw;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic int win_base(input int w);
    return (w / 4) * 16 + (w % 4) * 2;
  endfunction

  // Reference pooling of one window straight from the memory contents.
  function automatic logic [W-1:0] ref_pool(input int c, input int w, input bit relu);
    int b;
    logic signed [W-1:0] m;
    logic signed [W-1:0] v [4];
    b = win_base(w);
    v[0] = mem[c][b];
    v[1] = mem[c][b+1];
    v[2] = mem[c][b+8];
    v[3] = mem[c][b+9];
    m = v[0];
    for (int i = 1; i < 4; i++) if (v[i] > m) m = v[i];
    if (relu && m < 0) m = '0;
    return m;
  endfunction

  task automatic load_ramp();
    for (int c = 0; c < 3; c++)
      for (int a = 0; a < 64; a++) mem[c][a] = W'(c * 64 + a);
  endtask

  task automatic cmp_model(input string nm);
    int e1, e0;
    e1 = 0;
    e0 = 0;
    for (int c = 0; c < 3; c++)
      for (int w = 0; w < 16; w++) begin
        if (res1[c*16+w] !== ref_pool(c, w, 1'b1)) e1++;
        if (res0[c*16+w] !== ref_pool(c, w, 1'b0)) e0++;
      end
    check({nm, "_relu_on_bad_words"}, 64'(e1), 64'd0);
    check({nm, "_relu_off_bad_words"}, 64'(e0), 64'd0);
  endtask

  // Call just after a negedge. Pulses (or holds) start, follows the run until done or the limit.
  task automatic run(input bit hold, input int limit,
                     output int first_wr, output int done_cyc, output int nrd,
                     output int nwr, output int order_err);
    first_wr  = -1;
    done_cyc  = -1;
    nrd       = 0;
    nwr       = 0;
    order_err = 0;
    for (int i = 0; i < 48; i++) begin
      res1[i] = 'x;
      res0[i] = 'x;
    end
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (!hold) start = 1'b0;
        check("cycle1_rd0", {rd_en1, busy1, done1, rd_addr1, rd_ch1},
              {1'b1, 1'b1, 1'b0, 6'd0, 2'd0});
      end
      if (rd_en1) nrd++;
      if (wr_en0 !== wr_en1 || rd_en0 !== rd_en1) order_err++;
      if (wr_en1) begin
        if (first_wr < 0) first_wr = k;
        if (nwr < 48) begin
          if ({wr_ch1, wr_addr1} != 6'(nwr) || k != 6 * nwr + 6) order_err++;
          res1[nwr] = wr_data1;
          res0[nwr] = wr_data0;
        end
        nwr++;
      end
      if (done1) begin
        done_cyc = k;
        break;
      end
    end
    if (done_cyc < 0) $display("FAIL run_timeout: no done within %0d cycles", limit);
  endtask

  int fw, dc, nr, nw, oe, cnt, diff;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            ch win  v0        v1        v2        v3        relu on   relu off
    tbl[0] = '{1,  0, 16'hFFFB, 16'hFFFD, 16'hFFF9, 16'hFFF7, 16'h0000, 16'hFFFD};
    tbl[1] = '{0,  0, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h7FFF};
    tbl[2] = '{2,  0, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0000, 16'h8000};
    tbl[3] = '{0,  5, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0004, 16'h0004};
    tbl[4] = '{1, 15, 16'h0064, 16'hFFFF, 16'h0064, 16'h0032, 16'h0064, 16'h0064};
    tbl[5] = '{2, 10, 16'hFFEC, 16'hFFF6, 16'hFFE2, 16'hFFD8, 16'h0000, 16'hFFF6};
    tbl[6] = '{1,  6, 16'h0010, 16'h0030, 16'h0020, 16'hFFFF, 16'h0030, 16'h0030};

    reset = 1'b1;
    start = 1'b0;
    load_ramp();

    // Reset state
    #12;
    check("reset_outputs_relu_on",
          {rd_en1, rd_ch1, rd_addr1, wr_en1, wr_ch1, wr_addr1, wr_data1, busy1, done1}, 64'd0);
    check("reset_outputs_relu_off",
          {rd_en0, rd_ch0, rd_addr0, wr_en0, wr_ch0, wr_addr0, wr_data0, busy0, done0}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_after_release", {rd_en1, wr_en1, busy1, done1}, 64'd0);

    // Ramp run
    run(1'b0, 400, fw, dc, nr, nw, oe);
    check("ramp_first_write_cycle", 64'(fw), 64'd6);
    check("ramp_done_cycle", 64'(dc), 64'd289);
    check("ramp_reads", 64'(nr), 64'd192);
    check("ramp_writes", 64'(nw), 64'd48);
    check("ramp_order", 64'(oe), 64'd0);
    check("ramp_busy_done", {busy1, done1, busy0, done0}, {1'b0, 1'b1, 1'b0, 1'b1});
    check("ramp_ch0_a0", 64'(res1[0]), 64'd9);
    check("ramp_ch0_a15", 64'(res1[15]), 64'd63);
    check("ramp_ch2_a0", 64'(res1[32]), 64'd137);
    check("ramp_ch2_a15", 64'(res1[47]), 64'd191);
    cmp_model("ramp");
    for (int i = 0; i < 48; i++) begin
      prev1[i] = res1[i];
      prev0[i] = res0[i];
    end

    // Back-to-back: idle in DONE until cycle 295, then start again
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (rd_en1 || wr_en1 || busy1 || !done1) cnt++;
    end
    check("done_hold_quiet", 64'(cnt), 64'd0);
    run(1'b0, 400, fw, dc, nr, nw, oe);
    check("b2b_first_write_cycle", 64'(fw), 64'd6);
    check("b2b_done_cycle", 64'(dc), 64'd289);
    check("b2b_reads", 64'(nr), 64'd192);
    check("b2b_order", 64'(oe), 64'd0);
    diff = 0;
    for (int i = 0; i < 48; i++)
      if (res1[i] !== prev1[i] || res0[i] !== prev0[i]) diff++;
    check("b2b_same_results", 64'(diff), 64'd0);

    // start held high for a whole run, then still high in DONE
    run(1'b1, 400, fw, dc, nr, nw, oe);
    check("hold_done_cycle", 64'(dc), 64'd289);
    check("hold_reads", 64'(nr), 64'd192);
    check("hold_writes", 64'(nw), 64'd48);
    @(negedge clk);
    check("hold_restart_cycle290", {rd_en1, busy1, done1, rd_addr1}, {1'b1, 1'b1, 1'b0, 6'd0});
    start = 1'b0;

    // Reset at cycle 100 of that run
    repeat (99) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrun_reset_relu_on",
          {rd_en1, rd_ch1, rd_addr1, wr_en1, wr_ch1, wr_addr1, wr_data1, busy1, done1}, 64'd0);
    check("midrun_reset_relu_off",
          {rd_en0, rd_ch0, rd_addr0, wr_en0, wr_ch0, wr_addr0, wr_data0, busy0, done0}, 64'd0);
    cnt = 0;
    repeat (2) begin
      @(negedge clk);
      if (rd_en1 || wr_en1 || busy1 || done1) cnt++;
    end
    reset = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (rd_en1 || wr_en1 || busy1 || done1 || rd_en0 || wr_en0) cnt++;
    end
    check("after_reset_no_strobes", 64'(cnt), 64'd0);

    // Table vectors, run after the reset
    load_ramp();
    for (int i = 0; i < 7; i++) begin
      mem[tbl[i].ch][win_base(tbl[i].win)]     = tbl[i].v0;
      mem[tbl[i].ch][win_base(tbl[i].win) + 1] = tbl[i].v1;
      mem[tbl[i].ch][win_base(tbl[i].win) + 8] = tbl[i].v2;
      mem[tbl[i].ch][win_base(tbl[i].win) + 9] = tbl[i].v3;
    end
    run(1'b0, 400, fw, dc, nr, nw, oe);
    check("post_reset_first_write_cycle", 64'(fw), 64'd6);
    check("post_reset_done_cycle", 64'(dc), 64'd289);
    check("post_reset_reads", 64'(nr), 64'd192);
    check("post_reset_order", 64'(oe), 64'd0);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("tbl%0d_relu_on", i), 64'(res1[tbl[i].ch*16 + tbl[i].win]), 64'(tbl[i].exp_relu));
      check($sformatf("tbl%0d_relu_off", i), 64'(res0[tbl[i].ch*16 + tbl[i].win]), 64'(tbl[i].exp_raw));
    end
    cmp_model("table");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pool2_engine.md
# pool2_engine

2x2/stride-2 max-pooling engine downstream of the conv2 stage. Once conv2 has filled its 3-channel 8x8 output memory, this block reads it back, reduces each non-overlapping 2x2 window to its signed maximum, optionally applies ReLU, and writes a 3-channel 4x4 result into the pool2 output memory that feeds the fully-connected stage. Addressing, read-latency alignment and completion signalling are all internal.

## Interface

Parameters:
- DATA_W, 16: width of a signed feature-map word, in and out.
- RELU_EN, 1: 1 = clamp negative pooled results to 0 before writing; 0 = write the raw max.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high; clock clk.
- start  in  1  run request; sampled only in IDLE or DONE.
- rd_en  out  1  read strobe to the conv2 output memory.
- rd_ch  out  2  channel select for the read (0..2).
- rd_addr  out  6  pixel address for the read, row*8+col.
- rd_data  in  DATA_W  signed read data, valid the cycle after rd_en (1-cycle synchronous RAM).
- wr_en  out  1  write strobe to the pool2 output memory.
- wr_ch  out  2  channel select for the write.
- wr_addr  out  4  pooled address, prow*4+pcol.
- wr_data  out  DATA_W  pooled result.
- busy  out  1  high while a run is in progress.
- done  out  1  high from run completion until the next accepted start or reset.

## Operation

- States: IDLE, RD0, RD1, RD2, RD3, WAIT, WRITE, DONE.
- IDLE/DONE, start=1: clear ch/prow/pcol, clear done, go to RD0. Otherwise hold the current state.
- RDk (k=0..3): rd_en=1, rd_ch=ch. rd_addr takes these values in order:
  - RD0: (2*prow)*8 + 2*pcol
  - RD1: RD0 address + 1
  - RD2: RD0 address + 8
  - RD3: RD0 address + 9
- WAIT: rd_en=0. The last read's data returns during this state.
- Max register: loaded directly (no compare) from the data returned for RD0. Each later datum replaces it when it is strictly greater, using a signed compare. On ties the register keeps its value.
- WRITE: wr_en=1, wr_ch=ch, wr_addr=prow*4+pcol, wr_data=max. If RELU_EN and max<0, wr_data=0.
- After WRITE, counters advance: pcol first, then prow, then ch (ch outer, pcol inner).
  - pcol wraps 3->0 and increments prow.
  - prow wraps 3->0 and increments ch.
  - When ch=2, prow=3, pcol=3 has been written, go to DONE. Otherwise return to RD0.
- DONE: done=1, busy=0, all strobes low.
- start while busy (RD0..WRITE) is ignored. It neither restarts nor extends the run.
- rd_data is ignored outside the cycles in which return data is expected.

## Timing

- Reset values: rd_en=0, rd_ch=0, rd_addr=0, wr_en=0, wr_ch=0, wr_addr=0, wr_data=0, busy=0, done=0. State is IDLE and all counters and the max register are 0.
- All outputs are registered.
- Latency is defined from edge E, the edge at which start=1 is sampled:
  - Cycle 1 after E: first RD0, rd_addr=0. busy rises.
  - Window period is 6 cycles (RD0..RD3, WAIT, WRITE).
  - First write: cycle 6, wr_addr=0.
  - Window n (0..47): writes in cycle 6n+6.
  - Last write: cycle 288.
  - Cycle 289: done=1, busy=0.
- Read/return alignment: data for an address issued in cycle c is consumed at the end of cycle c+1. Returns fall in RD1, RD2, RD3 and WAIT.
- Exactly 192 read strobes and 48 write strobes per run. Each strobe is a single-cycle pulse.
- Reset asserted mid-run: all outputs are forced to reset values immediately (asynchronous). No further reads or writes occur. After deassertion the block waits in IDLE for a fresh start.
- Restart from DONE: start at edge E clears done in cycle 1, and the timing above repeats exactly.

## Test plan

- Ramp run: memory word = ch*64 + addr, start pulse.
  - Expect 48 writes in ch-major, then row, then col order.
  - ch0 wr_addr 0 = 9; ch0 wr_addr 15 = 63; ch2 wr_addr 0 = 137; ch2 wr_addr 15 = 191.
  - First write in cycle 6, done in cycle 289, 192 reads total.
- Negatives with RELU_EN=1: ch1 window (0,0) = {-5, -3, -7, -9}, expect wr_data=0. Same stimulus with RELU_EN=0: expect wr_data=-3 (0xFFFD at DATA_W=16).
- Signed extremes and ties: window = {0x8000, 0x7FFF, 0x7FFF, 0x0000} -> 0x7FFF. All four = 0x8000 with RELU_EN=0 -> 0x8000, proving the first element is loaded rather than compared against 0.
- start held high for the whole run: exactly one run occurs, done rises at cycle 289, no second RD0 before done. With start still high in DONE, a new run begins at cycle 290.
- Reset at cycle 100: all outputs are 0 immediately and no wr_en follows. A start after release produces a full 288-cycle run from wr_addr 0, ch 0.
- Back-to-back runs: second start in cycle 295. done clears in the next cycle and results are identical to the first run.
